// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer.
//
// Keeps dispatched instructions in program order. Completion arrives by ROB
// index over CDB_WIDTH channels. Retirement is in order, up to WAY per cycle,
// and hands T_old back to the free list. A retiring mispredicted branch raises
// flush and empties the whole buffer on the next edge.
//
// Ports
//   clock, reset             single clock; synchronous active-high reset
//   disp_valid/pr/told/ar/pc dispatch requests (thermometer, slot 0 oldest)
//   dispatch_num, disp_idx   slots accepted this cycle and the index of slot k
//   free_slots               min(free entries, WAY) from the pre-edge count
//   rob_empty, rob_full      occupancy flags
//   cdb_valid/idx/mispred/target  completion channels
//   retire_valid/told/pr/ar  retiring entries (thermometer, oldest first)
//   retire_num               number of retiring entries
//   flush, recovery_pc       mispredicted branch retiring and its target
module rob_param #(
  parameter int ROB_DEPTH = 32,
  parameter int WAY       = 2,
  parameter int CDB_WIDTH = 4,
  parameter int PR_BITS   = 7,
  parameter int AR_BITS   = 5,
  parameter int IDX_BITS  = $clog2(ROB_DEPTH)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [WAY-1:0]                disp_valid,
  input  logic [WAY*PR_BITS-1:0]        disp_pr,
  input  logic [WAY*PR_BITS-1:0]        disp_told,
  input  logic [WAY*AR_BITS-1:0]        disp_ar,
  input  logic [WAY*64-1:0]             disp_pc,
  output logic [$clog2(WAY+1)-1:0]      dispatch_num,
  output logic [WAY*IDX_BITS-1:0]       disp_idx,
  output logic [$clog2(WAY+1)-1:0]      free_slots,
  output logic                          rob_empty,
  output logic                          rob_full,
  input  logic [CDB_WIDTH-1:0]          cdb_valid,
  input  logic [CDB_WIDTH*IDX_BITS-1:0] cdb_idx,
  input  logic [CDB_WIDTH-1:0]          cdb_mispred,
  input  logic [CDB_WIDTH*64-1:0]       cdb_target,
  output logic [WAY-1:0]                retire_valid,
  output logic [WAY*PR_BITS-1:0]        retire_told,
  output logic [WAY*PR_BITS-1:0]        retire_pr,
  output logic [WAY*AR_BITS-1:0]        retire_ar,
  output logic [$clog2(WAY+1)-1:0]      retire_num,
  output logic                          flush,
  output logic [63:0]                   recovery_pc
);
  localparam int NB = $clog2(WAY+1);
  localparam int CB = IDX_BITS + 1;

  logic [ROB_DEPTH-1:0] valid_r;
  logic [ROB_DEPTH-1:0] complete_r;
  logic [ROB_DEPTH-1:0] mispred_r;
  logic [63:0]          target_r [ROB_DEPTH];
  logic [PR_BITS-1:0]   pr_r     [ROB_DEPTH];
  logic [PR_BITS-1:0]   told_r   [ROB_DEPTH];
  logic [AR_BITS-1:0]   ar_r     [ROB_DEPTH];
  logic [63:0]          pc_r     [ROB_DEPTH];
  logic [IDX_BITS-1:0]  head_r;
  logic [IDX_BITS-1:0]  tail_r;
  logic [CB-1:0]        count_r;

  logic [CB-1:0]        room_s;
  logic [NB-1:0]        req_s;
  logic                 unused_pc_s;

  // The PC is carried per entry for trace/debug visibility; retire does not consume it.
  assign unused_pc_s = ^pc_r[head_r];

  assign rob_empty = (count_r == {CB{1'b0}});
  assign rob_full  = (count_r == CB'(ROB_DEPTH));

  // Free-slot count, dispatch acceptance and slot index assignment.
  always_comb begin
    room_s = CB'(ROB_DEPTH) - count_r;
    if (room_s < CB'(WAY)) begin
      free_slots = NB'(room_s);
    end else begin
      free_slots = NB'(WAY);
    end
    req_s = {NB{1'b0}};
    for (int k = 0; k < WAY; k++) begin
      req_s = req_s + NB'(disp_valid[k]);
    end
    // A flushing cycle accepts nothing so the requester keeps holding its slots.
    if (flush) begin
      dispatch_num = {NB{1'b0}};
    end else if (req_s < free_slots) begin
      dispatch_num = req_s;
    end else begin
      dispatch_num = free_slots;
    end
    for (int k = 0; k < WAY; k++) begin
      disp_idx[k*IDX_BITS +: IDX_BITS] = IDX_BITS'(tail_r + IDX_BITS'(k));
    end
  end

  // In-order retire scan from head; stops at the first incomplete entry or just after a mispredict.
  always_comb begin
    logic                go;
    logic [IDX_BITS-1:0] slot;
    go           = 1'b1;
    slot         = head_r;
    retire_valid = {WAY{1'b0}};
    retire_num   = {NB{1'b0}};
    retire_told  = {(WAY*PR_BITS){1'b0}};
    retire_pr    = {(WAY*PR_BITS){1'b0}};
    retire_ar    = {(WAY*AR_BITS){1'b0}};
    flush        = 1'b0;
    recovery_pc  = 64'd0;
    for (int k = 0; k < WAY; k++) begin
      slot = IDX_BITS'(head_r + IDX_BITS'(k));
      retire_told[k*PR_BITS +: PR_BITS] = told_r[slot];
      retire_pr[k*PR_BITS +: PR_BITS]   = pr_r[slot];
      retire_ar[k*AR_BITS +: AR_BITS]   = ar_r[slot];
      if (go && valid_r[slot] && complete_r[slot]) begin
        retire_valid[k] = 1'b1;
        retire_num      = retire_num + NB'(1);
        flush           = mispred_r[slot];
        recovery_pc     = mispred_r[slot] ? target_r[slot] : 64'd0;
        go              = ~mispred_r[slot];
      end else begin
        go = 1'b0;
      end
    end
  end

  // Entry state, pointers and occupancy; reset and flush both empty the buffer.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      valid_r    <= {ROB_DEPTH{1'b0}};
      complete_r <= {ROB_DEPTH{1'b0}};
      mispred_r  <= {ROB_DEPTH{1'b0}};
      head_r     <= {IDX_BITS{1'b0}};
      tail_r     <= {IDX_BITS{1'b0}};
      count_r    <= {CB{1'b0}};
    end else begin
      // Later channels overwrite earlier ones, so the highest channel wins on duplicates.
      for (int c = 0; c < CDB_WIDTH; c++) begin
        if (cdb_valid[c] && valid_r[cdb_idx[c*IDX_BITS +: IDX_BITS]]) begin
          complete_r[cdb_idx[c*IDX_BITS +: IDX_BITS]] <= 1'b1;
          mispred_r[cdb_idx[c*IDX_BITS +: IDX_BITS]]  <= cdb_mispred[c];
          target_r[cdb_idx[c*IDX_BITS +: IDX_BITS]]   <= cdb_target[c*64 +: 64];
        end
      end
      for (int k = 0; k < WAY; k++) begin
        if (retire_valid[k]) begin
          valid_r[IDX_BITS'(head_r + IDX_BITS'(k))] <= 1'b0;
        end
      end
      // Dispatch lands only on entries that were free before this edge, never on retiring ones.
      for (int k = 0; k < WAY; k++) begin
        if (NB'(k) < dispatch_num) begin
          valid_r[IDX_BITS'(tail_r + IDX_BITS'(k))]    <= 1'b1;
          complete_r[IDX_BITS'(tail_r + IDX_BITS'(k))] <= 1'b0;
          mispred_r[IDX_BITS'(tail_r + IDX_BITS'(k))]  <= 1'b0;
          pr_r[IDX_BITS'(tail_r + IDX_BITS'(k))]       <= disp_pr[k*PR_BITS +: PR_BITS];
          told_r[IDX_BITS'(tail_r + IDX_BITS'(k))]     <= disp_told[k*PR_BITS +: PR_BITS];
          ar_r[IDX_BITS'(tail_r + IDX_BITS'(k))]       <= disp_ar[k*AR_BITS +: AR_BITS];
          pc_r[IDX_BITS'(tail_r + IDX_BITS'(k))]       <= disp_pc[k*64 +: 64];
        end
      end
      head_r  <= IDX_BITS'(head_r + IDX_BITS'(retire_num));
      tail_r  <= IDX_BITS'(tail_r + IDX_BITS'(dispatch_num));
      count_r <= count_r + CB'(dispatch_num) - CB'(retire_num);
    end
  end
endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param (DEPTH=8, WAY=2, 4 CDB channels): a dispatch table,
// hand-written multi-cycle sequences, then random traffic against a
// queue-based reference model.
module tb_rob_param;
  localparam int DEPTH = 8;
  localparam int WAY   = 2;
  localparam int CDBW  = 4;
  localparam int PRB   = 7;
  localparam int ARB   = 5;
  localparam int IB    = 3;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [WAY-1:0]       disp_valid;
  logic [WAY*PRB-1:0]   disp_pr, disp_told;
  logic [WAY*ARB-1:0]   disp_ar;
  logic [WAY*64-1:0]    disp_pc;
  logic [1:0]           dispatch_num, free_slots, retire_num;
  logic [WAY*IB-1:0]    disp_idx;
  logic                 rob_empty, rob_full, flush;
  logic [CDBW-1:0]      cdb_valid, cdb_mispred;
  logic [CDBW*IB-1:0]   cdb_idx;
  logic [CDBW*64-1:0]   cdb_target;
  logic [WAY-1:0]       retire_valid;
  logic [WAY*PRB-1:0]   retire_told, retire_pr;
  logic [WAY*ARB-1:0]   retire_ar;
  logic [63:0]          recovery_pc;

  rob_param #(.ROB_DEPTH(DEPTH), .WAY(WAY), .CDB_WIDTH(CDBW), .PR_BITS(PRB), .AR_BITS(ARB)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_pr(disp_pr), .disp_told(disp_told), .disp_ar(disp_ar), .disp_pc(disp_pc),
    .dispatch_num(dispatch_num), .disp_idx(disp_idx), .free_slots(free_slots),
    .rob_empty(rob_empty), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
    .retire_valid(retire_valid), .retire_told(retire_told), .retire_pr(retire_pr), .retire_ar(retire_ar),
    .retire_num(retire_num), .flush(flush), .recovery_pc(recovery_pc)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] dv;
    int         dn;
    int         i0;
    int         i1;
    int         fr;
    logic       full;
    logic       empty;
  } vec_t;
  vec_t tab [5];

  typedef struct {
    logic [6:0]  pr;
    logic [6:0]  told;
    logic [4:0]  ar;
    logic        cmp;
    logic        mp;
    logic [63:0] tgt;
    int          idx;
  } ent_t;
  ent_t mq[$];
  int   mhead;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    reset       = 1'b0;
    disp_valid  = '0;
    disp_pr     = '0;
    disp_told   = '0;
    disp_ar     = '0;
    disp_pc     = '0;
    cdb_valid   = '0;
    cdb_idx     = '0;
    cdb_mispred = '0;
    cdb_target  = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clr_in();
  endtask

  task automatic set_disp(input logic [1:0] dv, input int pr0, input int told0);
    disp_valid = dv;
    for (int k = 0; k < WAY; k++) begin
      disp_pr[k*PRB +: PRB]   = PRB'(pr0 + k);
      disp_told[k*PRB +: PRB] = PRB'(told0 + k);
      disp_ar[k*ARB +: ARB]   = ARB'(pr0 + k);
      disp_pc[k*64 +: 64]     = 64'(32'h1000 + 4 * (pr0 + k));
    end
  endtask

  task automatic set_cdb(input int ch, input int idx, input logic mp, input logic [63:0] tgt);
    cdb_valid[ch]          = 1'b1;
    cdb_idx[ch*IB +: IB]   = IB'(idx);
    cdb_mispred[ch]        = mp;
    cdb_target[ch*64 +: 64] = tgt;
  endtask

  task automatic chk_reset_state(input string tag);
    #1;
    chk({tag, "_rv"},    retire_valid, 0);
    chk({tag, "_rnum"},  retire_num, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_rpc"},   recovery_pc, 0);
    chk({tag, "_dn"},    dispatch_num, 0);
    chk({tag, "_idx0"},  disp_idx[2:0], 0);
    chk({tag, "_idx1"},  disp_idx[5:3], 1);
    chk({tag, "_free"},  free_slots, 2);
    chk({tag, "_empty"}, rob_empty, 1);
    chk({tag, "_full"},  rob_full, 0);
  endtask

  // One random cycle: drive stimulus, compare against the queue model, advance the model.
  task automatic rand_cycle();
    int          n, sz, fr, rn, dn, tail, idx;
    logic        fl;
    logic [63:0] rec;
    logic [1:0]  ev;
    ent_t        e;
    n = $urandom_range(0, 2);
    disp_valid = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
    for (int k = 0; k < WAY; k++) begin
      disp_pr[k*PRB +: PRB]   = PRB'($urandom);
      disp_told[k*PRB +: PRB] = PRB'($urandom);
      disp_ar[k*ARB +: ARB]   = ARB'($urandom);
      disp_pc[k*64 +: 64]     = {$urandom, $urandom};
    end
    for (int c = 0; c < CDBW; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) idx = mq[$urandom_range(0, mq.size() - 1)].idx;
        else idx = $urandom_range(0, DEPTH - 1);
        set_cdb(c, idx, ($urandom_range(0, 9) == 0), {$urandom, $urandom});
      end
    end
    reset = ($urandom_range(0, 149) == 0);
    #1;
    sz  = mq.size();
    fr  = (DEPTH - sz < WAY) ? DEPTH - sz : WAY;
    rn  = 0;
    fl  = 1'b0;
    rec = 64'd0;
    for (int k = 0; k < WAY && k < sz; k++) begin
      if (!mq[k].cmp) break;
      chk("rnd_told", retire_told[k*PRB +: PRB], mq[k].told);
      chk("rnd_pr",   retire_pr[k*PRB +: PRB],   mq[k].pr);
      chk("rnd_ar",   retire_ar[k*ARB +: ARB],   mq[k].ar);
      rn++;
      if (mq[k].mp) begin
        fl  = 1'b1;
        rec = mq[k].tgt;
        break;
      end
    end
    ev = 2'b00;
    for (int k = 0; k < rn; k++) ev[k] = 1'b1;
    dn   = fl ? 0 : ((n < fr) ? n : fr);
    tail = (mhead + sz) % DEPTH;
    chk("rnd_rv",    retire_valid, ev);
    chk("rnd_rnum",  retire_num, rn);
    chk("rnd_flush", flush, fl);
    chk("rnd_rpc",   recovery_pc, rec);
    chk("rnd_dn",    dispatch_num, dn);
    chk("rnd_free",  free_slots, fr);
    chk("rnd_idx0",  disp_idx[2:0], tail % DEPTH);
    chk("rnd_idx1",  disp_idx[5:3], (tail + 1) % DEPTH);
    chk("rnd_empty", rob_empty, sz == 0);
    chk("rnd_full",  rob_full, sz == DEPTH);
    if (reset || fl) begin
      mq.delete();
      mhead = 0;
    end else begin
      for (int c = 0; c < CDBW; c++) begin
        if (cdb_valid[c]) begin
          for (int q = 0; q < mq.size(); q++) begin
            if (mq[q].idx == int'(cdb_idx[c*IB +: IB])) begin
              e      = mq[q];
              e.cmp  = 1'b1;
              e.mp   = cdb_mispred[c];
              e.tgt  = cdb_target[c*64 +: 64];
              mq[q]  = e;
            end
          end
        end
      end
      for (int k = 0; k < rn; k++) void'(mq.pop_front());
      mhead = (mhead + rn) % DEPTH;
      for (int k = 0; k < dn; k++) begin
        e.pr   = disp_pr[k*PRB +: PRB];
        e.told = disp_told[k*PRB +: PRB];
        e.ar   = disp_ar[k*ARB +: ARB];
        e.cmp  = 1'b0;
        e.mp   = 1'b0;
        e.tgt  = 64'd0;
        e.idx  = (tail + k) % DEPTH;
        mq.push_back(e);
      end
    end
    tick();
  endtask

  initial begin
    tab[0] = '{2'b11, 2, 0, 1, 2, 1'b0, 1'b1};
    tab[1] = '{2'b11, 2, 2, 3, 2, 1'b0, 1'b0};
    tab[2] = '{2'b11, 2, 4, 5, 2, 1'b0, 1'b0};
    tab[3] = '{2'b11, 2, 6, 7, 2, 1'b0, 1'b0};
    tab[4] = '{2'b11, 0, 0, 1, 0, 1'b1, 1'b0};

    clr_in();
    reset = 1'b1;
    tick();
    chk_reset_state("reset");

    // Fill an 8-deep ROB two per cycle: T=32.., T_old=0..
    for (int i = 0; i < 5; i++) begin
      set_disp(tab[i].dv, 32 + 2 * i, 2 * i);
      #1;
      chk($sformatf("tab%0d_dn", i),    dispatch_num, tab[i].dn);
      chk($sformatf("tab%0d_idx0", i),  disp_idx[2:0], tab[i].i0);
      chk($sformatf("tab%0d_idx1", i),  disp_idx[5:3], tab[i].i1);
      chk($sformatf("tab%0d_free", i),  free_slots, tab[i].fr);
      chk($sformatf("tab%0d_full", i),  rob_full, tab[i].full);
      chk($sformatf("tab%0d_empty", i), rob_empty, tab[i].empty);
      tick();
    end

    // Out-of-order completion: idx1 then idx0.
    set_cdb(0, 1, 1'b0, 64'd0); #1; chk("ooo_hold_a", retire_num, 0); tick();
    set_cdb(0, 0, 1'b0, 64'd0); #1; chk("ooo_hold_b", retire_num, 0); tick();
    set_disp(2'b11, 40, 8); #1;
    chk("ooo_rnum", retire_num, 2);
    chk("ooo_told0", retire_told[6:0], 0);
    chk("ooo_told1", retire_told[13:7], 1);
    chk("ooo_pr0", retire_pr[6:0], 32);
    chk("ooo_pr1", retire_pr[13:7], 33);
    chk("full_retire_dn", dispatch_num, 0);
    chk("full_retire_full", rob_full, 1);
    tick();
    set_disp(2'b11, 40, 8); #1;
    chk("after_full_dn", dispatch_num, 2);
    chk("wrap_idx0", disp_idx[2:0], 0);
    chk("wrap_idx1", disp_idx[5:3], 1);
    chk("wrap_hold", retire_num, 0);
    tick();

    // Retire across the 7 -> 0 wrap.
    set_cdb(0, 2, 1'b0, 64'd0); set_cdb(1, 3, 1'b0, 64'd0);
    set_cdb(2, 4, 1'b0, 64'd0); set_cdb(3, 5, 1'b0, 64'd0);
    #1; chk("wrap_full", rob_full, 1); tick();
    set_cdb(0, 6, 1'b0, 64'd0); set_cdb(1, 7, 1'b0, 64'd0);
    set_cdb(2, 0, 1'b0, 64'd0); set_cdb(3, 1, 1'b0, 64'd0);
    #1;
    chk("wrap_rnum_a", retire_num, 2);
    chk("wrap_told_a0", retire_told[6:0], 2);
    chk("wrap_told_a1", retire_told[13:7], 3);
    tick();
    for (int j = 0; j < 3; j++) begin
      #1;
      chk($sformatf("wrap_rnum_%0d", j), retire_num, 2);
      chk($sformatf("wrap_told0_%0d", j), retire_told[6:0], 4 + 2 * j);
      chk($sformatf("wrap_told1_%0d", j), retire_told[13:7], 5 + 2 * j);
      tick();
    end
    #1;
    chk("wrap_empty", rob_empty, 1);
    chk("wrap_rnum_end", retire_num, 0);

    // Count 7 then a 2-wide request: only one slot accepted.
    for (int j = 0; j < 3; j++) begin
      set_disp(2'b11, 50 + 2 * j, 20 + 2 * j);
      tick();
    end
    set_disp(2'b01, 56, 26); tick();
    set_disp(2'b11, 57, 27); #1;
    chk("cnt7_dn", dispatch_num, 1);
    chk("cnt7_free", free_slots, 1);
    chk("cnt7_idx0", disp_idx[2:0], 1);
    tick();
    #1;
    chk("cnt7_full", rob_full, 1);
    chk("cnt7_tail", disp_idx[2:0], 2);

    // Mispredict on the second-oldest entry; duplicate index, highest channel wins.
    set_cdb(0, 2, 1'b0, 64'd0);
    set_cdb(1, 3, 1'b0, 64'h999);
    set_cdb(2, 4, 1'b0, 64'd0);
    set_cdb(3, 3, 1'b1, 64'h400);
    #1;
    chk("cdb_not_same_cycle", retire_num, 0);
    tick();
    set_disp(2'b11, 60, 30);
    set_cdb(0, 5, 1'b1, 64'h777);
    #1;
    chk("mp_rnum", retire_num, 2);
    chk("mp_told0", retire_told[6:0], 20);
    chk("mp_told1", retire_told[13:7], 21);
    chk("mp_flush", flush, 1);
    chk("mp_rpc", recovery_pc, 64'h400);
    chk("mp_dn", dispatch_num, 0);
    tick();
    #1;
    chk("postflush_empty", rob_empty, 1);
    chk("postflush_full", rob_full, 0);
    chk("postflush_rnum", retire_num, 0);
    chk("postflush_flush", flush, 0);
    chk("postflush_rpc", recovery_pc, 0);
    chk("postflush_idx0", disp_idx[2:0], 0);
    chk("postflush_idx1", disp_idx[5:3], 1);
    chk("postflush_free", free_slots, 2);

    // Strobe to an invalid entry is ignored; then minimum completion latency.
    set_disp(2'b11, 60, 30);
    set_cdb(0, 0, 1'b0, 64'd0);
    #1; chk("lat_dn", dispatch_num, 2);
    tick();
    #1; chk("cdb_invalid_ign", retire_num, 0);
    set_cdb(0, 0, 1'b0, 64'd0); set_cdb(1, 1, 1'b0, 64'd0);
    #1; chk("cdb_latency", retire_num, 0);
    tick();
    #1;
    chk("lat_rnum", retire_num, 2);
    chk("lat_told0", retire_told[6:0], 30);
    chk("lat_told1", retire_told[13:7], 31);
    tick();

    // Reset over a full ROB with active CDB and dispatch.
    for (int j = 0; j < 4; j++) begin
      set_disp(2'b11, 70 + 2 * j, 40 + 2 * j);
      tick();
    end
    #1; chk("prereset_full", rob_full, 1);
    reset = 1'b1;
    set_disp(2'b11, 80, 50);
    set_cdb(0, 2, 1'b1, 64'habc);
    set_cdb(1, 3, 1'b0, 64'd0);
    tick();
    chk_reset_state("midreset");

    // Random traffic against the queue model.
    reset = 1'b1;
    tick();
    mq.delete();
    mhead = 0;
    repeat (400) rand_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
